pc_sequencer: RTL and testbench

//  Multi-cycle fetch/next-PC controller for the NPC core; sits between the IFU memory port and decode/execute.

---
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch / next-PC controller.
// The controller issues a fetch, then holds the instruction while execute runs.
// It then resolves the branch and commits the next PC. It also counts retired
// instructions, and it stops on ebreak or on a committed target with bit 1 set.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_valid/ready/addr      fetch request handshake; addr always equals pc
//   ifu_resp_valid/inst           single-cycle fetch response
//   inst_valid, inst, pc          held instruction and current PC for decode/execute
//   exe_done                      execute finished; branch/zero/less/imm/rs1/halt_req valid
//   branch, zero, less, imm, rs1  branch resolution inputs (3-bit branch encoding)
//   halt_req                      ebreak seen, sampled with exe_done
//   halted, trap_misalign         core stopped / sticky misaligned-target flag
//   retire_cnt                    retired instruction count (wraps)
module pc_sequencer #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_resp_valid,
  input  logic [31:0]     ifu_resp_inst,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            exe_done,
  input  logic [2:0]      branch,
  input  logic            zero,
  input  logic            less,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            halt_req,
  output logic            halted,
  output logic            trap_misalign,
  output logic [63:0]     retire_cnt
);

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    EXEC       = 2'd2,
    HALT       = 2'd3
  } state_t;

  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc_nxt;
  logic [31:0]       inst_nxt;
  logic              inst_valid_nxt;
  logic              halted_nxt;
  logic              trap_nxt;
  logic [63:0]       retire_nxt;
  logic              taken;
  logic [XLEN-1:0]   target;

  // Unused/reserved encodings (000, 011) resolve as not taken.
  function automatic logic branch_taken(input logic [2:0] br, input logic z, input logic lt);
    logic t;
    case (br)
      BR_JAL, BR_JALR: t = 1'b1;
      BR_BEQ:          t = z;
      BR_BNE:          t = ~z;
      BR_BLT:          t = lt;
      BR_BGE:          t = ~lt;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

  // jalr is relative to rs1 and drops bit 0 of the sum. The sum wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_target(input logic [2:0] br, input logic tk,
                                                  input logic [XLEN-1:0] cur_pc,
                                                  input logic [XLEN-1:0] base_rs1,
                                                  input logic [XLEN-1:0] offs);
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] off;
    logic [XLEN-1:0] sum;
    base = (br == BR_JALR) ? base_rs1 : cur_pc;
    off  = tk ? offs : XLEN'(4);
    sum  = base + off;
    if (br == BR_JALR) sum[0] = 1'b0;
    return sum;
  endfunction

  assign taken  = branch_taken(branch, zero, less);
  assign target = next_target(branch, taken, pc, rs1, imm);

  // The request is masked during the reset cycle, whatever state was left behind.
  assign ifu_req_valid = (state == FETCH_REQ) && !rst;
  assign ifu_req_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH_REQ;
      pc            <= RESET_PC;
      inst          <= '0;
      inst_valid    <= 1'b0;
      halted        <= 1'b0;
      trap_misalign <= 1'b0;
      retire_cnt    <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      inst          <= inst_nxt;
      inst_valid    <= inst_valid_nxt;
      halted        <= halted_nxt;
      trap_misalign <= trap_nxt;
      retire_cnt    <= retire_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_nxt       = inst;
    inst_valid_nxt = inst_valid;
    halted_nxt     = halted;
    trap_nxt       = trap_misalign;
    retire_nxt     = retire_cnt;
    case (state)
      FETCH_REQ: begin
        // A response arriving here is stale and is ignored.
        if (ifu_req_ready) state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (ifu_resp_valid) begin
          inst_nxt       = ifu_resp_inst;
          inst_valid_nxt = 1'b1;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        if (exe_done) begin
          inst_valid_nxt = 1'b0;
          if (halt_req) begin
            // ebreak retires but does not advance the PC, and it overrides any branch.
            retire_nxt = retire_cnt + 64'd1;
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end else if (taken && target[1]) begin
            // The faulting instruction does not retire, and the PC keeps pointing at it.
            trap_nxt   = 1'b1;
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end else begin
            pc_nxt     = target;
            retire_nxt = retire_cnt + 64'd1;
            state_nxt  = FETCH_REQ;
          end
        end
      end
      HALT: begin
        inst_valid_nxt = 1'b0;
        halted_nxt     = 1'b1;
      end
      default: state_nxt = FETCH_REQ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        exe_done;
  logic [2:0]  branch;
  logic        zero;
  logic        less;
  logic [63:0] imm;
  logic [63:0] rs1;
  logic        halt_req;
  logic        halted;
  logic        trap_misalign;
  logic [63:0] retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst),
    .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .exe_done(exe_done), .branch(branch), .zero(zero), .less(less), .imm(imm), .rs1(rs1),
    .halt_req(halt_req), .halted(halted), .trap_misalign(trap_misalign), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; exe_done = 1'b0; halt_req = 1'b0; branch = 3'b000;
    zero = 1'b0; less = 1'b0; imm = '0; rs1 = '0;
    ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for a held instruction, then presents one exe_done cycle.
  task automatic do_inst(input logic [2:0] br, input logic z, input logic lt,
                         input logic [63:0] im, input logic [63:0] r1, input logic hr,
                         output logic got, output logic [31:0] seen);
    got  = 1'b0;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      seen = inst;
      branch = br; zero = z; less = lt; imm = im; rs1 = r1; halt_req = hr; exe_done = 1'b1;
      @(posedge clk);
      #1 exe_done = 1'b0; halt_req = 1'b0; branch = 3'b000;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; exe_done = 1'b0; halt_req = 1'b0; branch = 3'b000;
    zero = 1'b0; less = 1'b0; imm = '0; rs1 = '0;
    ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0000_0013;
    @(negedge clk);
    n_checks++; if (ifu_req_valid !== 1'b0) $display("FAIL rst_req_valid got=%b exp=0", ifu_req_valid); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 64'h8000_0000) $display("FAIL rst_pc got=%h exp=%h", pc, 64'h8000_0000); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); else n_pass++;
    n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst got=%h exp=0", inst); else n_pass++;
    n_checks++; if (halted !== 1'b0 || trap_misalign !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", halted, trap_misalign); else n_pass++;
    n_checks++; if (retire_cnt !== 64'd0) $display("FAIL rst_retire got=%0d exp=0", retire_cnt); else n_pass++;
    n_checks++; if (ifu_req_valid !== 1'b1 || ifu_req_addr !== 64'h8000_0000) $display("FAIL rst_first_req got=%b/%h exp=1/80000000", ifu_req_valid, ifu_req_addr); else n_pass++;
  endtask

  task automatic test_sequential();
    logic got;
    logic [31:0] seen;
    logic [63:0] exp_pc;
    exp_pc = 64'h8000_0000;
    for (int k = 0; k < 3; k++) begin
      do_inst(3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, got, seen);
      exp_pc = exp_pc + 64'd4;
      n_checks++; if (got !== 1'b1) $display("FAIL seq_timeout%0d got=%b exp=1", k, got); else n_pass++;
      n_checks++; if (seen !== 32'h0000_0013) $display("FAIL seq_inst%0d got=%h exp=00000013", k, seen); else n_pass++;
      n_checks++; if (pc !== exp_pc) $display("FAIL seq_pc%0d got=%h exp=%h", k, pc, exp_pc); else n_pass++;
    end
    n_checks++; if (retire_cnt !== 64'd3) $display("FAIL seq_retire got=%0d exp=3", retire_cnt); else n_pass++;
  endtask

  task automatic test_branches();
    logic got;
    logic [31:0] seen;
    logic [2:0]  br_v  [10] = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001};
    logic        z_v   [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        l_v   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] imm_v [10] = '{64'd0, -64'sd8, 64'd0, 64'd0, -64'sd8, 64'h20, 64'h10, 64'h10, 64'h100, 64'h100};
    logic [63:0] pc_v  [10] = '{64'h8000_0010, 64'h8000_0008, 64'h8000_000C, 64'h8000_0010, 64'h8000_0014,
                                64'h8000_0034, 64'h8000_0044, 64'h8000_0048, 64'h8000_004C, 64'h8000_014C};
    for (int k = 0; k < 10; k++) begin
      do_inst(br_v[k], z_v[k], l_v[k], imm_v[k], 64'h1234_5678, 1'b0, got, seen);
      n_checks++; if (got !== 1'b1 || pc !== pc_v[k]) $display("FAIL br_pc%0d got=%h exp=%h", k, pc, pc_v[k]); else n_pass++;
    end
    n_checks++; if (retire_cnt !== 64'd13) $display("FAIL br_retire got=%0d exp=13", retire_cnt); else n_pass++;
    n_checks++; if (trap_misalign !== 1'b0 || halted !== 1'b0) $display("FAIL br_flags got=%b%b exp=00", trap_misalign, halted); else n_pass++;
  endtask

  task automatic test_jalr();
    logic got;
    logic [31:0] seen;
    do_inst(3'b010, 1'b0, 1'b0, 64'd3, 64'h8000_1001, 1'b0, got, seen);
    n_checks++; if (got !== 1'b1 || pc !== 64'h8000_1004) $display("FAIL jalr_pc got=%h exp=80001004", pc); else n_pass++;
    n_checks++; if (trap_misalign !== 1'b0) $display("FAIL jalr_trap got=%b exp=0", trap_misalign); else n_pass++;
  endtask

  task automatic test_ready_stall();
    logic got;
    logic [31:0] seen;
    // The sequencer sits in FETCH_REQ right now; hold off the handshake.
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (ifu_req_valid !== 1'b1 || ifu_req_addr !== 64'h8000_1004) $display("FAIL stall_req%0d got=%b/%h exp=1/80001004", k, ifu_req_valid, ifu_req_addr); else n_pass++;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL stall_resp_ignored%0d got=%b exp=0", k, inst_valid); else n_pass++;
    end
    ifu_req_ready = 1'b1; ifu_resp_inst = 32'h0040_0093;
    do_inst(3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, got, seen);
    n_checks++; if (got !== 1'b1 || seen !== 32'h0040_0093) $display("FAIL stall_inst got=%h exp=00400093", seen); else n_pass++;
    n_checks++; if (pc !== 64'h8000_1008 || retire_cnt !== 64'd15) $display("FAIL stall_commit got=%h/%0d exp=80001008/15", pc, retire_cnt); else n_pass++;
  endtask

  task automatic test_halt();
    logic got;
    logic [31:0] seen;
    apply_reset();
    for (int k = 0; k < 7; k++) do_inst(3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, got, seen);
    n_checks++; if (retire_cnt !== 64'd7 || pc !== 64'h8000_001C) $display("FAIL halt_pre got=%0d/%h exp=7/8000001c", retire_cnt, pc); else n_pass++;
    do_inst(3'b001, 1'b0, 1'b0, 64'h40, 64'd0, 1'b1, got, seen);
    n_checks++; if (got !== 1'b1 || halted !== 1'b1) $display("FAIL halt_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (retire_cnt !== 64'd8) $display("FAIL halt_retire got=%0d exp=8", retire_cnt); else n_pass++;
    n_checks++; if (pc !== 64'h8000_001C || trap_misalign !== 1'b0) $display("FAIL halt_pc got=%h/%b exp=8000001c/0", pc, trap_misalign); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (ifu_req_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL halt_quiet%0d got=%b%b exp=00", k, ifu_req_valid, inst_valid); else n_pass++;
    end
  endtask

  task automatic test_misalign();
    logic got;
    logic [31:0] seen;
    apply_reset();
    do_inst(3'b010, 1'b0, 1'b0, 64'd2, 64'h8000_1000, 1'b0, got, seen);
    n_checks++; if (got !== 1'b1 || trap_misalign !== 1'b1 || halted !== 1'b1) $display("FAIL mis_flags got=%b%b exp=11", trap_misalign, halted); else n_pass++;
    n_checks++; if (pc !== 64'h8000_0000) $display("FAIL mis_pc got=%h exp=80000000", pc); else n_pass++;
    n_checks++; if (retire_cnt !== 64'd0) $display("FAIL mis_retire got=%0d exp=0", retire_cnt); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (ifu_req_valid !== 1'b0 || trap_misalign !== 1'b1) $display("FAIL mis_sticky got=%b%b exp=01", ifu_req_valid, trap_misalign); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic got;
    logic [31:0] seen;
    apply_reset();
    n_checks++; if (halted !== 1'b0 || trap_misalign !== 1'b0) $display("FAIL mid_rst_clears got=%b%b exp=00", halted, trap_misalign); else n_pass++;
    ifu_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ifu_req_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL mid_wait got=%b%b exp=00", ifu_req_valid, inst_valid); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_inst = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL mid_stray_resp got=%b exp=0", inst_valid); else n_pass++;
    n_checks++; if (pc !== 64'h8000_0000 || ifu_req_valid !== 1'b1 || ifu_req_addr !== 64'h8000_0000) $display("FAIL mid_new_req got=%b/%h exp=1/80000000", ifu_req_valid, ifu_req_addr); else n_pass++;
    ifu_req_ready = 1'b1; ifu_resp_inst = 32'h0000_0013;
    do_inst(3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, got, seen);
    n_checks++; if (got !== 1'b1 || pc !== 64'h8000_0004 || retire_cnt !== 64'd1) $display("FAIL mid_resume got=%h/%0d exp=80000004/1", pc, retire_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branches();
    test_jalr();
    test_ready_stall();
    test_halt();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
